// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: decode/pipeline control bundle; master drives instr_d and flush_e, slave (pipe_ctrl) returns stall_d, cw_pipe and md_busy
interface pipe_ctrl_if #(parameter int STAGES = 3);
  logic [31:0] instr_d;
  logic flush_e;
  logic stall_d;
  logic [STAGES*25-1:0] cw_pipe;
  logic md_busy;
  modport master (output instr_d, flush_e, input stall_d, cw_pipe, md_busy);
  modport slave (input instr_d, flush_e, output stall_d, cw_pipe, md_busy);
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: decodes instr_d into a 25-bit control word, pipes it through STAGES stages and raises stall_d on load-use, branch-use and mul/div hazards; ports clk, reset (sync, active-low), bus (pipe_ctrl_if.slave); mul/div support enabled by PIPE_CTRL_MD_EN
module pipe_ctrl #(
  parameter int STAGES = 3,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input logic clk,
  input logic reset,
  pipe_ctrl_if.slave bus
);
  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd, wreg;
  logic [2:0] md_op, branch, memwrite, aluop, memtoreg;
  logic [1:0] ext_sel;
  logic shift_sel, alusrc, regwrite, vld;
  logic [24:0] dec, s1_d, s1_q, s2_q;
  logic [STAGES*25-1:0] cw_q, cw_d;
  logic ld1, ld2, wr1, hit1, hit2, is_jr, is_bb, use_ld, use_br, md_stall;
  assign op = bus.instr_d[31:26];
  assign rs = bus.instr_d[25:21];
  assign rt = bus.instr_d[20:16];
  assign rd = bus.instr_d[15:11];
  assign fn = bus.instr_d[5:0];
  always_comb begin
    md_op = '0;
    shift_sel = 1'b0;
    ext_sel = '0;
    branch = '0;
    memwrite = '0;
    alusrc = 1'b0;
    aluop = '0;
    regwrite = 1'b1;
    memtoreg = '0;
    vld = 1'b1;
    case (op)
      6'h00: case (fn)
        6'h20, 6'h21: aluop = 3'b010;
        6'h22, 6'h23: aluop = 3'b110;
        6'h24: aluop = 3'b000;
        6'h25: aluop = 3'b001;
        6'h2a: aluop = 3'b011;
        6'h2b: aluop = 3'b100;
        6'h08: begin branch = 3'b011; regwrite = 1'b0; end
`ifdef PIPE_CTRL_MD_EN
        6'h18: begin md_op = 3'b001; regwrite = 1'b0; end
        6'h19: begin md_op = 3'b010; regwrite = 1'b0; end
        6'h1a: begin md_op = 3'b011; regwrite = 1'b0; end
        6'h1b: begin md_op = 3'b100; regwrite = 1'b0; end
        6'h11: begin md_op = 3'b101; regwrite = 1'b0; end
        6'h13: begin md_op = 3'b110; regwrite = 1'b0; end
        6'h10, 6'h12: begin md_op = 3'b111; memtoreg = 3'b100; end
`endif
        default: vld = 1'b0;
      endcase
      6'h03: begin branch = 3'b010; memtoreg = 3'b011; end
      6'h04: begin branch = 3'b001; aluop = 3'b110; regwrite = 1'b0; end
      6'h05: begin branch = 3'b100; aluop = 3'b110; regwrite = 1'b0; end
      6'h08: begin alusrc = 1'b1; aluop = 3'b010; end
      6'h0c: begin alusrc = 1'b1; ext_sel = 2'b01; end
      6'h0d: begin alusrc = 1'b1; aluop = 3'b001; ext_sel = 2'b01; end
      6'h0f: begin alusrc = 1'b1; shift_sel = 1'b1; memtoreg = 3'b010; end
      6'h20, 6'h21, 6'h23: begin alusrc = 1'b1; aluop = 3'b010; memtoreg = 3'b001; end
      6'h28: begin alusrc = 1'b1; aluop = 3'b010; memtoreg = 3'b001; memwrite = 3'b011; regwrite = 1'b0; end
      6'h29: begin alusrc = 1'b1; aluop = 3'b010; memtoreg = 3'b001; memwrite = 3'b010; regwrite = 1'b0; end
      6'h2b: begin alusrc = 1'b1; aluop = 3'b010; memtoreg = 3'b001; memwrite = 3'b001; regwrite = 1'b0; end
      default: vld = 1'b0;
    endcase
    // only writing R-type ops (ALU, mfhi/mflo) target rd
    wreg = op == 6'h03 ? 5'd31 : (op == 6'h00 && regwrite) ? rd : rt;
    dec = vld ? {md_op, shift_sel, ext_sel, branch, memwrite, alusrc, aluop, regwrite, memtoreg, wreg} : '0;
  end
  assign s1_q = cw_q[24:0];
  assign s2_q = cw_q[49:25];
  assign ld1 = s1_q[8] && s1_q[7:5] == 3'b001 && s1_q[4:0] != 5'd0;
  assign ld2 = s2_q[8] && s2_q[7:5] == 3'b001 && s2_q[4:0] != 5'd0;
  assign wr1 = s1_q[8] && s1_q[4:0] != 5'd0;
  assign is_jr = dec[18:16] == 3'b011;
  assign is_bb = dec[18:16] == 3'b001 || dec[18:16] == 3'b100;
  // jr only reads rs; beq/bne compare both sources
  assign hit1 = s1_q[4:0] == rs || (is_bb && s1_q[4:0] == rt);
  assign hit2 = s2_q[4:0] == rs || (is_bb && s2_q[4:0] == rt);
  assign use_ld = ld1 && (s1_q[4:0] == rs || s1_q[4:0] == rt);
  assign use_br = (is_jr || is_bb) && ((wr1 && hit1) || (ld2 && hit2));
`ifdef PIPE_CTRL_MD_EN
  logic [4:0] cnt_q, cnt_d;
  logic busy_q;
  // counter starts the cycle after a mul/div sits in stage 1, which the stage-1 stall term covers
  always_comb cnt_d = s1_q[24:22] inside {3'b001, 3'b010} ? 5'(MULT_LAT) :
                      s1_q[24:22] inside {3'b011, 3'b100} ? 5'(DIV_LAT) : cnt_q - {4'd0, |cnt_q};
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      busy_q <= |cnt_d;
    end
  end
  assign md_stall = dec[24:22] != 3'b000 && (busy_q || s1_q[24:22] inside {3'b001, 3'b010, 3'b011, 3'b100});
  assign bus.md_busy = busy_q;
`else
  assign md_stall = 1'b0;
  assign bus.md_busy = 1'b0;
`endif
  assign bus.stall_d = use_ld | use_br | md_stall;
  assign s1_d = (bus.stall_d || bus.flush_e) ? '0 : dec;
  assign cw_d = {cw_q[STAGES*25-26:0], s1_d};
  always_ff @(posedge clk) cw_q <= !reset ? '0 : cw_d;
  assign bus.cw_pipe = cw_q;
endmodule
